// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the program loader: FSM
//                state encoding, frame header codes and the memory word width.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

  // Width of one instruction/data memory word and of the load address.
  localparam int WORD_W = 32;

  // Frame header codes.
  localparam logic [7:0] HDR_IMEM = 8'h01;
  localparam logic [7:0] HDR_DMEM = 8'h02;
  localparam logic [7:0] HDR_END  = 8'hFF;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_ADDR  = 3'd1,
    ST_CNT   = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  // States in which the loader is willing to take a byte from the stream.
  function automatic logic state_accepts(input state_t s);
    return (s == ST_HDR) || (s == ST_ADDR) || (s == ST_CNT) || (s == ST_DATA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : word_assembler
//  Description : Collects accepted stream bytes into a 32-bit little-endian
//                word. Each byte is shifted in from the top, so after four
//                bytes the first byte sits in [7:0]; after two bytes the
//                16-bit little-endian value sits in [31:16].
//  Ports       : clk      - clock
//                rst      - synchronous active-high reset
//                clr_i    - restart field (byte index and word cleared)
//                valid_i  - a byte is accepted this cycle
//                byte_i   - accepted byte
//                idx_o    - index (0..3) of the byte position being filled
//                word_o   - word as it looks including the byte on byte_i
//  Revision    : 1.0 - initial release
// ============================================================================
module word_assembler
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              valid_i,
  input  logic [7:0]        byte_i,
  output logic [1:0]        idx_o,
  output logic [WORD_W-1:0] word_o
);

  logic [1:0]        idx_q;
  logic [1:0]        idx_d;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;
  logic [WORD_W-1:0] shift_w;

  // The completed value is visible in the same cycle as the last byte, so
  // the parent can latch it without waiting an extra clock.
  assign shift_w = {byte_i, word_q[WORD_W-1:8]};

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clr_i) begin
      idx_d  = 2'd0;
      word_d = '0;
    end else if (valid_i) begin
      idx_d  = idx_q + 2'd1;   // wraps to 0 after a full word
      word_d = shift_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= 2'd0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign idx_o  = idx_q;
  assign word_o = shift_w;

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Byte-stream program loader. Parses frames of
//                  header(1) | address(4, LE) | word count(2, LE) | N words(4, LE)
//                and writes each word into instruction or data memory through
//                a one-cycle load strobe. Header 0xFF ends the load and
//                releases the downstream core from reset; any protocol
//                violation parks the loader in a sticky error state.
//  Ports       : clk       - clock
//                rst       - synchronous active-high reset
//                in_valid  - stream byte valid
//                in_data   - stream byte
//                in_ready  - loader accepts a byte this cycle
//                IMLD/IMWD/IMA - instruction memory strobe / data / byte addr
//                DMLD/DMWD/DMA - data memory strobe / data / byte addr
//                core_rst  - downstream core reset, released on done
//                done      - load finished (sticky)
//                error     - protocol error (sticky)
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              IMLD,
  output logic [WORD_W-1:0] IMWD,
  output logic [WORD_W-1:0] IMA,
  output logic              DMLD,
  output logic [WORD_W-1:0] DMWD,
  output logic [WORD_W-1:0] DMA,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  state_t            state_q;
  state_t            state_d;
  logic              tgt_dm_q;     // 1: data memory, 0: instruction memory
  logic [WORD_W-1:0] addr_q;
  logic [15:0]       cnt_q;

  logic              in_ready_q;
  logic              imld_q;
  logic              dmld_q;
  logic [WORD_W-1:0] imwd_q;
  logic [WORD_W-1:0] ima_q;
  logic [WORD_W-1:0] dmwd_q;
  logic [WORD_W-1:0] dma_q;
  logic              core_rst_q;
  logic              done_q;
  logic              error_q;

  logic              accept;
  logic              asm_valid;
  logic              asm_clr;
  logic [1:0]        asm_idx;
  logic [WORD_W-1:0] asm_word;
  logic              field_last;
  logic              cnt_last;
  logic              hdr_load;

  assign accept    = in_valid & in_ready_q;
  assign asm_valid = accept &
                     ((state_q == ST_ADDR) || (state_q == ST_CNT) || (state_q == ST_DATA));

  // Address and data fields are four bytes and wrap the byte index by
  // themselves; the count field is only two bytes, so the assembler is
  // restarted on its second byte.
  assign field_last = asm_valid & (asm_idx == 2'd3);
  assign cnt_last   = asm_valid & (state_q == ST_CNT) & (asm_idx == 2'd1);
  assign asm_clr    = cnt_last;

  assign hdr_load = (in_data == HDR_IMEM) || (in_data == HDR_DMEM);

  word_assembler u_asm (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (asm_clr),
    .valid_i (asm_valid),
    .byte_i  (in_data),
    .idx_o   (asm_idx),
    .word_o  (asm_word)
  );

  // Next-state decode; all registers, including outputs, update in the
  // single sequential block below.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR: begin
        if (accept) begin
          if (hdr_load)                state_d = ST_ADDR;
          else if (in_data == HDR_END) state_d = ST_DONE;
          else                         state_d = ST_ERR;
        end
      end
      ST_ADDR: begin
        if (field_last) begin
          state_d = (asm_word[1:0] != 2'b00) ? ST_ERR : ST_CNT;
        end
      end
      ST_CNT: begin
        if (cnt_last) begin
          state_d = (asm_word[31:16] == 16'd0) ? ST_HDR : ST_DATA;
        end
      end
      ST_DATA: begin
        if (field_last) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // cnt_q still holds the count before this write is retired.
        state_d = (cnt_q == 16'd1) ? ST_HDR : ST_DATA;
      end
      ST_DONE: state_d = ST_DONE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HDR;
      tgt_dm_q   <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= 16'd0;
      in_ready_q <= 1'b1;
      imld_q     <= 1'b0;
      dmld_q     <= 1'b0;
      imwd_q     <= '0;
      ima_q      <= '0;
      dmwd_q     <= '0;
      dma_q      <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Registered ready reflects the state the FSM is about to enter.
      in_ready_q <= state_accepts(state_d);
      imld_q     <= 1'b0;
      dmld_q     <= 1'b0;

      case (state_q)
        ST_HDR: begin
          if (accept && hdr_load) tgt_dm_q <= (in_data == HDR_DMEM);
        end
        ST_ADDR: begin
          if (field_last) addr_q <= asm_word;
        end
        ST_CNT: begin
          if (cnt_last) cnt_q <= asm_word[31:16];
        end
        ST_DATA: begin
          // Strobe and payload are registered here so they are presented
          // during the WRITE cycle that follows the last data byte.
          if (field_last) begin
            if (tgt_dm_q) begin
              dmld_q <= 1'b1;
              dmwd_q <= asm_word;
              dma_q  <= addr_q;
            end else begin
              imld_q <= 1'b1;
              imwd_q <= asm_word;
              ima_q  <= addr_q;
            end
          end
        end
        ST_WRITE: begin
          addr_q <= addr_q + 32'd4;   // modulo 2^32
          cnt_q  <= cnt_q - 16'd1;
        end
        default: ;
      endcase

      if (state_d == ST_DONE) begin
        done_q     <= 1'b1;
        core_rst_q <= 1'b0;
      end
      if (state_d == ST_ERR) begin
        error_q <= 1'b1;
      end
    end
  end

  assign in_ready = in_ready_q;
  // A reset arriving during the WRITE cycle must not let the strobe through.
  assign IMLD     = imld_q & ~rst;
  assign DMLD     = dmld_q & ~rst;
  assign IMWD     = imwd_q;
  assign IMA      = ima_q;
  assign DMWD     = dmwd_q;
  assign DMA      = dma_q;
  assign core_rst = core_rst_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Directed self-checking bench for program_loader. Expected
//                memory writes are queued as frames are driven and compared
//                by a monitor whenever a load strobe appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        IMLD;
  logic [31:0] IMWD;
  logic [31:0] IMA;
  logic        DMLD;
  logic [31:0] DMWD;
  logic [31:0] DMA;
  logic        core_rst;
  logic        done;
  logic        error;

  program_loader dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .IMLD     (IMLD),
    .IMWD     (IMWD),
    .IMA      (IMA),
    .DMLD     (DMLD),
    .DMWD     (DMWD),
    .DMA      (DMA),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        dm;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  gaps_en  = 1'b0;
  bit  raw_mode = 1'b0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (IMLD === 1'b1 || DMLD === 1'b1) begin
      check1("strobe_exclusive", IMLD & DMLD, 1'b0);
      check1("strobe_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check1("strobe_target", DMLD, mon_e.dm);
        if (mon_e.dm) begin
          check32("dm_addr", DMA, mon_e.a);
          check32("dm_data", DMWD, mon_e.d);
        end else begin
          check32("im_addr", IMA, mon_e.a);
          check32("im_data", IMWD, mon_e.d);
        end
      end
    end
  end

  // Drive one byte. Normal mode waits (bounded) for the handshake; raw mode
  // just presents the byte for a single cycle regardless of in_ready.
  task automatic send_byte(input logic [7:0] b);
    int t;
    if (gaps_en) begin
      repeat ($urandom_range(0, 2)) begin
        in_data = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    if (!raw_mode) begin
      while (in_ready !== 1'b1 && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 50) check1("ready_timeout", in_ready, 1'b1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_hdr(input logic [7:0] h, input logic [31:0] a, input logic [15:0] n);
    send_byte(h);
    send_word(a);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic do_reset;
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    in_valid = 1'b0;
    in_data  = 8'h00;

    // ---- Reset state ----
    do_reset();
    check1 ("rst_in_ready", in_ready, 1'b1);
    check1 ("rst_imld",     IMLD,     1'b0);
    check1 ("rst_dmld",     DMLD,     1'b0);
    check32("rst_ima",      IMA,      32'h0);
    check32("rst_imwd",     IMWD,     32'h0);
    check32("rst_dma",      DMA,      32'h0);
    check32("rst_dmwd",     DMWD,     32'h0);
    check1 ("rst_core_rst", core_rst, 1'b1);
    check1 ("rst_done",     done,     1'b0);
    check1 ("rst_error",    error,    1'b0);

    // ---- Two instruction words then end-of-load ----
    exp_q.push_back('{dm: 1'b0, a: 32'h0, d: 32'h0000_0013});
    exp_q.push_back('{dm: 1'b0, a: 32'h4, d: 32'h0010_0093});
    send_hdr(8'h01, 32'h0, 16'd2);
    send_word(32'h0000_0013);
    check1 ("imem_latency_strobe", IMLD,     1'b1);
    check1 ("imem_write_not_ready", in_ready, 1'b0);
    send_word(32'h0010_0093);
    send_byte(8'hFF);
    check1 ("imem_done",     done,     1'b1);
    check1 ("imem_core_rst", core_rst, 1'b0);
    check1 ("imem_done_rdy", in_ready, 1'b0);
    idle(3);
    check1 ("imem_done_sticky", done, 1'b1);
    check1 ("imem_all_written", exp_q.size() == 0, 1'b1);

    // ---- Single data-memory word ----
    do_reset();
    exp_q.push_back('{dm: 1'b1, a: 32'h10, d: 32'hDEAD_BEEF});
    send_hdr(8'h02, 32'h10, 16'd1);
    send_word(32'hDEAD_BEEF);
    check1 ("dmem_latency_strobe", DMLD, 1'b1);
    check1 ("dmem_no_imld",        IMLD, 1'b0);
    idle(3);
    check1 ("dmem_back_to_hdr", in_ready, 1'b1);
    check1 ("dmem_not_done",    done,     1'b0);
    check1 ("dmem_core_rst",    core_rst, 1'b1);
    check32("dmem_hold_dmwd",   DMWD,     32'hDEAD_BEEF);
    check32("dmem_ima_clean",   IMA,      32'h0);
    check1 ("dmem_all_written", exp_q.size() == 0, 1'b1);

    // ---- Bad header, then a valid frame that must be ignored ----
    do_reset();
    send_byte(8'h07);
    check1 ("badhdr_error",    error,    1'b1);
    check1 ("badhdr_core_rst", core_rst, 1'b1);
    check1 ("badhdr_ready",    in_ready, 1'b0);
    raw_mode = 1'b1;
    send_hdr(8'h01, 32'h0, 16'd1);
    send_word(32'h0000_0013);
    send_byte(8'hFF);
    raw_mode = 1'b0;
    idle(2);
    check1 ("badhdr_error_sticky", error, 1'b1);
    check1 ("badhdr_not_done",     done,  1'b0);
    check32("badhdr_imwd",         IMWD,  32'h0);

    // ---- Misaligned address ----
    do_reset();
    send_byte(8'h01);
    send_word(32'h0000_0002);
    check1 ("misalign_error", error,    1'b1);
    check1 ("misalign_ready", in_ready, 1'b0);
    raw_mode = 1'b1;
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h1234_5678);
    raw_mode = 1'b0;
    idle(2);
    check32("misalign_imwd", IMWD, 32'h0);
    check1 ("misalign_no_writes", exp_q.size() == 0, 1'b1);

    // ---- Address wrap and zero-count frame ----
    do_reset();
    exp_q.push_back('{dm: 1'b0, a: 32'hFFFF_FFFC, d: 32'hA5A5_0001});
    exp_q.push_back('{dm: 1'b0, a: 32'h0000_0000, d: 32'h5A5A_0002});
    send_hdr(8'h01, 32'hFFFF_FFFC, 16'd2);
    send_word(32'hA5A5_0001);
    send_word(32'h5A5A_0002);
    send_hdr(8'h02, 32'h20, 16'd0);
    check1 ("zero_cnt_ready", in_ready, 1'b1);
    check1 ("zero_cnt_error", error,    1'b0);
    send_byte(8'hFF);
    check1 ("wrap_done",      done,     1'b1);
    check32("wrap_hold_imwd", IMWD,     32'h5A5A_0002);
    check32("zero_cnt_dma",   DMA,      32'h0);
    check1 ("wrap_all_written", exp_q.size() == 0, 1'b1);

    // ---- Gapped stream, reset inside a data word, then a clean frame ----
    do_reset();
    gaps_en = 1'b1;
    exp_q.push_back('{dm: 1'b0, a: 32'h100, d: 32'hCAFE_F00D});
    send_hdr(8'h01, 32'h100, 16'd2);
    send_word(32'hCAFE_F00D);
    send_byte(8'h11);
    send_byte(8'h22);
    check32("gap_first_word_ima", IMA, 32'h100);
    rst = 1'b1;
    @(posedge clk); #1;
    check1 ("midrst_imld",     IMLD,     1'b0);
    check1 ("midrst_dmld",     DMLD,     1'b0);
    check32("midrst_ima",      IMA,      32'h0);
    check32("midrst_imwd",     IMWD,     32'h0);
    check1 ("midrst_core_rst", core_rst, 1'b1);
    check1 ("midrst_done",     done,     1'b0);
    check1 ("midrst_error",    error,    1'b0);
    rst = 1'b0;
    check1 ("midrst_ready",    in_ready, 1'b1);
    exp_q.push_back('{dm: 1'b1, a: 32'h8, d: 32'h1122_3344});
    send_hdr(8'h02, 32'h8, 16'd1);
    send_word(32'h1122_3344);
    send_byte(8'hFF);
    gaps_en = 1'b0;
    check1 ("clean_done",     done,     1'b1);
    check1 ("clean_core_rst", core_rst, 1'b0);
    check32("clean_dmwd",     DMWD,     32'h1122_3344);
    check32("clean_ima",      IMA,      32'h0);
    idle(2);
    check1 ("clean_all_written", exp_q.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
